// File: rtl/ila_capture_ctrl.sv
// ila_capture_ctrl: capture/readout sequencer for the ILA sample BRAM.
// Sequences a window of DEPTH samples through pre-trigger fill, armed wait
// and post-trigger fill, then streams it out oldest-first over valid/ready.
// Optional: define ILA_TRIG_EDGE_EN to qualify trigger on its rising edge.
module ila_capture_ctrl #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trigger,
    input  logic [ADDR_WIDTH-1:0] pre_trig,
    input  logic                  rd_start,
    input  logic                  rd_ready,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr_write,
    output logic [ADDR_WIDTH-1:0] bram_addr_read,
    output logic                  busy,
    output logic                  triggered,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic                  rd_valid,
    output logic                  rd_last
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, FLUSH, DONE, RD_ADDR, RD_DATA} state_t;

    state_t                state, nxt;
    logic [ADDR_WIDTH-1:0] wptr, p, cnt, raddr;
    logic [ADDR_WIDTH:0]   rem;
    logic                  cap_en, trig_fire, arm, trig_acc, rd_go, beat;

`ifdef ILA_TRIG_EDGE_EN
    logic trig_q;

    // previous trigger level, so a level held across ARMED entry does not fire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            trig_q <= 1'b0;
        else
            trig_q <= trigger;
    end

    assign trig_fire = trigger && !trig_q;
`else
    assign trig_fire = trigger;
`endif

    assign bram_addr_read = raddr;

    // transition strobes and next state; abort overrides everything and drops cap_en at once
    always_comb begin
        arm      = !abort && start && (state == IDLE || (state == DONE && !rd_start));
        trig_acc = !abort && state == ARMED && trig_fire;
        rd_go    = !abort && state == DONE && rd_start;
        beat     = !abort && state == RD_DATA && rd_ready;
        cap_en   = !abort && state inside {PRE, ARMED, POST};
        nxt      = state;
        case (state)
            IDLE:    nxt = arm ? (pre_trig == '0 ? ARMED : PRE) : IDLE;
            PRE:     nxt = cnt == ADDR_WIDTH'(1) ? ARMED : PRE;
            ARMED:   nxt = trig_acc ? (p == ADDR_WIDTH'(DEPTH - 1) ? FLUSH : POST) : ARMED;
            POST:    nxt = cnt == ADDR_WIDTH'(1) ? FLUSH : POST;
            FLUSH:   nxt = DONE;
            DONE:    nxt = rd_go ? RD_ADDR : arm ? (pre_trig == '0 ? ARMED : PRE) : DONE;
            RD_ADDR: nxt = RD_DATA;
            RD_DATA: nxt = beat ? (rem == (ADDR_WIDTH + 1)'(1) ? IDLE : RD_ADDR) : RD_DATA;
            default: nxt = IDLE;
        endcase
        if (abort)
            nxt = IDLE;
    end

    // state register and status outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
        end else begin
            state    <= nxt;
            busy     <= nxt inside {PRE, ARMED, POST, FLUSH};
            done     <= nxt == DONE;
            rd_valid <= nxt == RD_DATA;
            rd_last  <= nxt == RD_DATA && rem == (ADDR_WIDTH + 1)'(1);
        end
    end

    // write pointer, phase counter, trigger capture and readout pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr            <= '0;
            p               <= '0;
            cnt             <= '0;
            raddr           <= '0;
            rem             <= '0;
            trig_addr       <= '0;
            triggered       <= 1'b0;
            bram_we         <= 1'b0;
            bram_addr_write <= '0;
        end else begin
            bram_we         <= cap_en;
            bram_addr_write <= wptr;
            if (arm) begin
                p         <= pre_trig;
                cnt       <= pre_trig;
                wptr      <= '0;
                triggered <= 1'b0;
            end else if (cap_en) begin
                wptr <= wptr + 1'b1;
            end
            if (cap_en && (state == PRE || state == POST))
                cnt <= cnt - 1'b1;
            if (trig_acc) begin
                trig_addr <= wptr;
                triggered <= 1'b1;
                cnt       <= ADDR_WIDTH'(DEPTH - 1) - p;
            end
            if (abort)
                triggered <= 1'b0;
            if (rd_go) begin
                raddr <= trig_addr - p;
                rem   <= (ADDR_WIDTH + 1)'(DEPTH);
            end
            if (beat) begin
                raddr <= raddr + 1'b1;
                rem   <= rem - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ila_capture_ctrl.sv
// tb_ila_capture_ctrl: table-driven capture/readout runs with write and read scoreboards,
// plus hand sequences for abort in POST and reset during readout.
`timescale 1ns/1ps
module tb_ila_capture_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, trigger = 1'b0, rd_start = 1'b0, rd_ready = 1'b0;
    logic [AW-1:0] pre_trig = '0;
    logic          bram_we, busy, triggered, done, rd_valid, rd_last;
    logic [AW-1:0] bram_addr_write, bram_addr_read, trig_addr;

    typedef struct {
        logic [AW-1:0] a;
        logic          l;
    } rd_exp_t;

    typedef struct {
        int p;
        int d;
        int ta;
        bit rd;
        bit tog;
    } vec_t;

    logic [AW-1:0] wq[$];
    rd_exp_t       rq[$];
    vec_t          vt[6];
    int            compared = 0, mismatched = 0;
    logic          hold = 1'b0;
    logic [AW-1:0] hold_addr = '0;

    ila_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .trigger(trigger),
        .pre_trig(pre_trig), .rd_start(rd_start), .rd_ready(rd_ready), .bram_we(bram_we),
        .bram_addr_write(bram_addr_write), .bram_addr_read(bram_addr_read), .busy(busy),
        .triggered(triggered), .done(done), .trig_addr(trig_addr), .rd_valid(rd_valid),
        .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s: got an event, expected none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // scoreboard side: pop expected writes/beats and check the held address while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            hold <= 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(rd_valid), 32'd1);
                chk("hold_addr", 32'(bram_addr_read), 32'(hold_addr));
            end
            if (bram_we) begin
                if (wq.size() == 0)
                    fail("wr_extra");
                else
                    chk("wr_addr", 32'(bram_addr_write), 32'(wq.pop_front()));
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) begin
                    fail("rd_extra");
                end else begin
                    chk("rd_addr", 32'(bram_addr_read), 32'(rq[0].a));
                    chk("rd_last", 32'(rd_last), 32'(rq[0].l));
                    void'(rq.pop_front());
                end
            end
            hold      <= rd_valid && !rd_ready && !abort;
            hold_addr <= bram_addr_read;
        end
    end

    task automatic run_cap(input int p, input int d, input int ta);
        for (int i = 0; i < d + DEPTH; i++)
            wq.push_back(AW'(i));
        pre_trig = AW'(p);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        chk("trig_clr", 32'(triggered), 32'd0);
        repeat (p + d) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        chk("triggered", 32'(triggered), 32'd1);
        chk("trig_addr", 32'(trig_addr), 32'(ta));
        repeat (DEPTH - 1 - p) tick();
        chk("done_early", 32'(done), 32'd0);
        tick();
        chk("done", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("wr_left", 32'(wq.size()), 32'd0);
        wq.delete();
    endtask

    task automatic run_rd(input int p, input int ta, input bit tog);
        int cyc;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < DEPTH; i++)
            rq.push_back('{AW'(ta - p + i), i == DEPTH - 1});
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        cyc = 0;
        while (rq.size() != 0 && cyc < 200) begin
            rd_ready = tog ? pat[cyc % 4] : 1'b1;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_left", 32'(rq.size()), 32'd0);
        if (!tog)
            chk("rd_cycles", 32'(cyc), 32'd32);
        chk("rd_idle", {29'd0, busy, done, rd_valid}, 32'd0);
        rq.delete();
    endtask

    initial begin
        vt[0] = '{5, 5, 10, 1'b1, 1'b0};
        vt[1] = '{0, 0, 0, 1'b1, 1'b0};
        vt[2] = '{15, 3, 2, 1'b1, 1'b0};
        vt[3] = '{3, 20, 7, 1'b1, 1'b1};
        vt[4] = '{8, 0, 8, 1'b0, 1'b0};
        vt[5] = '{2, 40, 10, 1'b1, 1'b1};

        #12;
        chk("reset_outs", {14'd0, bram_we, bram_addr_write, bram_addr_read, busy, triggered,
                           done, trig_addr, rd_valid, rd_last}, 32'd0);
        rst_n = 1'b1;
        tick();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        tick();
        chk("rd_start_idle", {30'd0, rd_valid, done}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_cap(vt[k].p, vt[k].d, vt[k].ta);
            if (vt[k].rd)
                run_rd(vt[k].p, vt[k].ta, vt[k].tog);
        end

        for (int i = 0; i < 4; i++)
            wq.push_back(AW'(i));
        pre_trig = AW'(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        chk("pend_we", 32'(bram_we), 32'd1);
        chk("post_busy", {30'd0, busy, triggered}, 32'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_we", 32'(bram_we), 32'd0);
        chk("abort_state", {29'd0, busy, triggered, done}, 32'd0);
        chk("abort_wr_left", 32'(wq.size()), 32'd0);
        wq.delete();
        tick();

        run_cap(4, 1, 5);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        rd_ready = 1'b0;
        tick();
        chk("rd_valid_pre_rst", 32'(rd_valid), 32'd1);
        chk("rd_addr_pre_rst", 32'(bram_addr_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {14'd0, bram_we, bram_addr_write, bram_addr_read, busy, triggered,
                         done, trig_addr, rd_valid, rd_last}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {29'd0, busy, done, rd_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ila_capture_ctrl.md
Name: ila_capture_ctrl

Overview:
Capture/readout sequencer for the ILA sample BRAM (single write port, single read port, registered input stage, 1-cycle read latency).
- Drives the BRAM write enable and write address through pre-trigger fill, armed wait, and post-trigger fill.
- Records the trigger address.
- Streams the captured window out oldest-first over a valid/ready handshake, driving the BRAM read address.
- Sits between the trigger logic and the host/UART readout path.

Parameters:
ADDR_WIDTH, 9, BRAM address width; DEPTH = 2**ADDR_WIDTH samples per window

Ports:
clk  input  1  sample/system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  arm request; accepted only in IDLE or DONE
abort  input  1  return to IDLE from any state; highest priority
trigger  input  1  trigger condition, qualified in ARMED only
pre_trig  input  ADDR_WIDTH  pre-trigger sample count, latched on accepted start
rd_start  input  1  begin readout; accepted only in DONE
rd_ready  input  1  consumer accepts current sample
bram_we  output  1  BRAM write enable
bram_addr_write  output  ADDR_WIDTH  BRAM write address
bram_addr_read  output  ADDR_WIDTH  BRAM read address
busy  output  1  high in PRE, ARMED, POST, FLUSH
triggered  output  1  high from trigger acceptance until next start/abort
done  output  1  high in DONE
trig_addr  output  ADDR_WIDTH  address holding the trigger sample
rd_valid  output  1  BRAM read data valid for consumer
rd_last  output  1  with rd_valid on final sample of window

Behaviour:
- Reset: all outputs 0; state IDLE; write pointer wptr = 0.
- Interface rule: clock and reset are clk and rst_n (single clock, asynchronous active-low reset).
- Sample timing: the BRAM registers di before writing. A sample on di in cycle t is written in cycle t+1.
  - Controller computes cap_en and wptr combinationally per cycle.
  - bram_we and bram_addr_write are those values registered by one cycle.
- wptr increments by 1 on every cap_en cycle and wraps from DEPTH-1 to 0.
- Each capture starts at wptr = 0.
- States:
  - IDLE: cap_en = 0. On start, latch pre_trig to p; go PRE (or ARMED if p == 0).
  - PRE: cap_en = 1 for exactly p cycles; trigger ignored. Then go ARMED.
  - ARMED: cap_en = 1 continuously; pointer may wrap any number of times. On the first cycle with trigger == 1:
    - that sample is the trigger sample: trig_addr <= wptr, triggered <= 1;
    - load post counter = DEPTH-1-p;
    - go POST, or go FLUSH if the count is 0.
  - POST: cap_en = 1 for the post count; trigger ignored. Then go FLUSH.
  - FLUSH: cap_en = 0 for one cycle so the final registered write lands; then go DONE.
  - DONE: done = 1, BRAM holds the window.
    - rd_start: go RD_ADDR with raddr = trig_addr - p (mod DEPTH) and remaining = DEPTH.
    - start: rearm, as from IDLE.
    - rd_start has priority if both are high.
  - RD_ADDR: drive bram_addr_read = raddr for one cycle (BRAM latency); go RD_DATA.
  - RD_DATA: rd_valid = 1; bram_addr_read holds raddr, so data stays stable. rd_last = 1 when remaining == 1.
    - On rd_ready: raddr++ (wrap), remaining--.
    - If this was the last sample, go IDLE; otherwise go RD_ADDR.
    - Throughput: one sample per 2 cycles minimum.
- Total window = DEPTH samples: p before the trigger, the trigger sample, and DEPTH-1-p after.
- If fewer than p samples exist before trigger acceptance, which cannot occur because PRE enforces p: no special case.
- abort: next state IDLE. cap_en drops immediately; the one pending registered write still completes. rd_valid, done and triggered are cleared next cycle.
- start in any state other than IDLE/DONE: ignored. rd_start outside DONE: ignored.
- Asynchronous reset mid-capture or mid-readout: immediate IDLE, outputs 0. BRAM contents are undefined for the next readout.

Optional Feature:
ILA_TRIG_EDGE_EN
- Defined: trigger is qualified as a rising edge (trigger && !trigger_q). trigger_q is a register reset to 0 and sampled every cycle, so a trigger held high across ARMED entry does not fire.
- Undefined: level-sensitive as described above. No extra register.

Test Plan:
- ADDR_WIDTH=4, pre_trig=5, start, trigger first high after 10 capture cycles -> writes at addresses 0..15,0..4 (21 writes); trig_addr=10; done 2 cycles after the last cap_en cycle.
- Same run, rd_start, rd_ready=1 -> bram_addr_read sequence 5..15,0..4; 16 rd_valid beats; rd_last only on address 4; then IDLE.
- pre_trig=0, trigger high at start -> trig_addr=0, 16 writes at 0..15, no PRE cycles.
- pre_trig=15, trigger arrives after a wrap -> no POST; FLUSH immediately; readout starts at trig_addr+1.
- Readout with rd_ready toggling 1-0-0-1 -> rd_valid held with a stable address while ready is low; no beat skipped or duplicated.
- abort in POST -> bram_we low within 1 cycle after the pending write; busy=0 and triggered=0 next cycle. Async rst_n pulse in RD_DATA -> all outputs 0 immediately.
